// File: rtl/alu_seq_unit.sv
// Handshaked ALU: ADD/SUB/shifts in 1 cycle, MUL via iterative shift-add (1+WIDTH cycles).
// Optional `ALU_MUL_EARLY_EXIT_EN ends MUL once the remaining multiplier bits are zero.
module alu_seq_unit #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_ctr,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0110;

    typedef enum logic [1:0] {IDLE, MUL_BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mcand, mplier, acc;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] alu_res, acc_sum;
    logic             alu_err, mul_last, go_busy;
    logic [SHW-1:0]   shamt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign shamt     = in_b[SHW-1:0];

    always_comb begin
        state_nxt = state;
        alu_res   = '0;
        alu_err   = 1'b0;
        acc_sum   = acc + (mplier[0] ? mcand : '0);
        mul_last  = (cnt == SHW'(WIDTH - 1));
`ifdef ALU_MUL_EARLY_EXIT_EN
        mul_last  = mul_last || (mplier[WIDTH-1:1] == '0);
        go_busy   = (in_ctr == OP_MUL) && (in_b != '0);
`else
        go_busy   = (in_ctr == OP_MUL);
`endif
        case (in_ctr)
            OP_ADD:  alu_res = in_a + in_b;
            OP_SUB:  alu_res = in_a - in_b;
            OP_MUL:  alu_res = '0;   // only used when MUL completes at the accept edge (B==0)
            OP_SLL:  alu_res = in_a << shamt;
            OP_SRL:  alu_res = in_a >> shamt;
            OP_SRA:  alu_res = $signed(in_a) >>> shamt;
            default: alu_err = 1'b1;
        endcase
        case (state)
            IDLE:     if (in_valid) state_nxt = go_busy ? MUL_BUSY : DONE;
            MUL_BUSY: if (mul_last) state_nxt = DONE;
            DONE:     if (out_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            out_data <= '0;
            out_err  <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                out_data <= alu_res;
                out_err  <= alu_err;
                mcand    <= in_a;
                mplier   <= in_b;
                acc      <= '0;
                cnt      <= '0;
            end else if (state == MUL_BUSY) begin
                acc    <= acc_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (mul_last) begin
                    out_data <= acc_sum;
                    out_err  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: driver pushes expectations, monitor checks data, flag and latency.
module tb_alu_seq_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   in_ctr = 4'd0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_err;

    alu_seq_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctr(in_ctr),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] d;
        logic         e;
        int           acc;
        int           lat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int mul_lat(input logic [W-1:0] b);
`ifdef ALU_MUL_EARLY_EXIT_EN
        int msb = 0;
        if (b == '0) return 1;
        for (int i = 0; i < W; i++) if (b[i]) msb = i;
        return msb + 2;
`else
        return W + 1;
`endif
    endfunction

    // Monitor: checks the head expectation when a result first appears, then stability until handshake.
    bit           seen = 0;
    logic [W-1:0] held_d;
    logic         held_e;
    always @(negedge clk) begin
        if (rst) begin
            seen = 0;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_result", {31'd0, out_valid, out_data}, 64'd0);
            end else begin
                if (!seen) begin
                    chk("latency", 64'(cyc - q[0].acc + 1), 64'(q[0].lat));
                    chk("out_data", 64'(out_data), 64'(q[0].d));
                    chk("out_err", 64'(out_err), 64'(q[0].e));
                    held_d = out_data;
                    held_e = out_err;
                    seen = 1;
                end else begin
                    chk("held_data", {31'd0, out_err, out_data}, {31'd0, held_e, held_d});
                end
                chk("in_ready_while_done", 64'(in_ready), 64'd0);
                if (out_ready) begin
                    void'(q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while ((q.size() != 0 || !in_ready) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) begin
            chk("idle_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] d, input logic e, input int lat);
        exp_t x;
        wait_idle();
        in_valid = 1'b1; in_ctr = op; in_a = a; in_b = b;
        @(posedge clk); #1;
        x.d = d; x.e = e; x.acc = cyc; x.lat = lat;
        q.push_back(x);
        in_valid = 1'b0; in_ctr = 4'hx; in_a = 'x; in_b = 'x;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        issue(4'b0000, 32'h00000001, 32'hffffffff, 32'h00000000, 1'b0, 1);
        issue(4'b0001, 32'h00000001, 32'h00000002, 32'hffffffff, 1'b0, 1);
        issue(4'b0010, 32'hfffffffb, 32'h00000005, 32'hffffffe7, 1'b0, mul_lat(32'h5));
        issue(4'b0010, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0, mul_lat(32'h00010000));

        // Backpressure: SRA result held for three cycles with out_ready low
        wait_idle();
        out_ready = 1'b0;
        issue(4'b0110, 32'h80000000, 32'h0000001f, 32'hffffffff, 1'b0, 1);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_accept", 64'(in_ready), 64'd1);

        issue(4'b0011, 32'h12345678, 32'h00000001, 32'h00000000, 1'b1, 1);
        issue(4'b0100, 32'h00000001, 32'h0000001f, 32'h80000000, 1'b0, 1);
        issue(4'b1000, 32'hdeadbeef, 32'h00000003, 32'h00000000, 1'b1, 1);
        issue(4'b0101, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1);
        issue(4'b0100, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1);
        issue(4'b0110, 32'h40000000, 32'h00000004, 32'h04000000, 1'b0, 1);

        // Reset in the middle of a MUL: no result may escape
        issue(4'b0010, 32'h00000003, 32'h00000007, 32'h00000015, 1'b0, mul_lat(32'h7));
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        issue(4'b0000, 32'h00000002, 32'hffffffff, 32'h00000001, 1'b0, 1);

        issue(4'b0010, 32'h00000005, 32'h00000005, 32'h00000019, 1'b0, mul_lat(32'h5));
        issue(4'b0010, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0, mul_lat(32'h0));
        issue(4'b0010, 32'hfffffffb, 32'hfffffffb, 32'h00000019, 1'b0, mul_lat(32'hfffffffb));
        issue(4'b0010, 32'h0000000d, 32'h00000001, 32'h0000000d, 1'b0, mul_lat(32'h1));

        wait_idle();
        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
